// File: rtl/pulse_sequencer.sv
// pulse_sequencer: multi-channel timed pulse-issue buffer.
// The core pushes {channel, delay, addr} descriptors. Each channel keeps them in its own
// FIFO and fires each one after its delay. Every fire is a one-cycle strobe on
// pulse_valid, and pulse_addr holds the address of the last fire. A channel can reload
// from its FIFO on the same edge that it fires.
module pulse_sequencer #(
  parameter int NUM_CH  = 4,
  parameter int DEPTH   = 8,
  parameter int DELAY_W = 16,
  parameter int ADDR_W  = 12,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CH_W-1:0]          in_ch,
  input  logic [DELAY_W-1:0]       in_delay,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic                     pause,
  input  logic                     flush,
  output logic [NUM_CH-1:0]        pulse_valid,
  output logic [NUM_CH*ADDR_W-1:0] pulse_addr,
  output logic [NUM_CH-1:0]        ch_full,
  output logic                     idle,
  output logic                     err_bad_ch
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = DELAY_W + ADDR_W;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t             state_q      [NUM_CH];
  logic [DELAY_W-1:0] cnt_q        [NUM_CH];
  logic [ADDR_W-1:0]  addr_q       [NUM_CH];
  logic [ENT_W-1:0]   mem_q        [NUM_CH][DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q     [NUM_CH];
  logic [PTR_W-1:0]   wr_ptr_q     [NUM_CH];
  logic [CNT_W-1:0]   count_q      [NUM_CH];
  logic [ADDR_W-1:0]  pulse_addr_q [NUM_CH];
  logic [NUM_CH-1:0]  fresh_q;       // entry written on the last edge, not yet poppable
  logic [NUM_CH-1:0]  pulse_valid_q;
  logic               err_q;

  logic              bad_ch, sel_full, push_ok;
  logic [NUM_CH-1:0] push, avail, load, fire;

  // Per-channel status: full, poppable head, fire and load decisions, global idle
  always_comb begin
    ch_full = '0;
    avail   = '0;
    fire    = '0;
    load    = '0;
    idle    = 1'b1;
    for (int k = 0; k < NUM_CH; k++) begin
      ch_full[k] = (count_q[k] == CNT_W'(DEPTH));
      // A freshly written entry becomes readable one cycle after its push edge
      avail[k]   = (count_q[k] > CNT_W'(fresh_q[k]));
      fire[k]    = !pause && (state_q[k] == S_WAIT) && (cnt_q[k] == '0);
      load[k]    = !pause && avail[k] && ((state_q[k] == S_IDLE) || fire[k]);
      if ((count_q[k] != '0) || (state_q[k] != S_IDLE)) idle = 1'b0;
    end
  end

  // Push handshake: refuse on a full target even if it pops this cycle; bad channels are swallowed
  always_comb begin
    bad_ch   = (int'(in_ch) >= NUM_CH);
    sel_full = 1'b0;
    for (int k = 0; k < NUM_CH; k++)
      if (in_ch == CH_W'(k)) sel_full = ch_full[k];
    in_ready = !reset && (bad_ch || !sel_full);
    push_ok  = in_valid && in_ready && !flush && !bad_ch;
    push     = '0;
    for (int k = 0; k < NUM_CH; k++)
      push[k] = push_ok && (in_ch == CH_W'(k));
  end

  // Control state: FIFO pointers/counts, channel FSMs, fire strobes and error strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        state_q[k]      <= S_IDLE;
        cnt_q[k]        <= '0;
        rd_ptr_q[k]     <= '0;
        wr_ptr_q[k]     <= '0;
        count_q[k]      <= '0;
        pulse_addr_q[k] <= '0;
      end
      fresh_q       <= '0;
      pulse_valid_q <= '0;
      err_q         <= 1'b0;
    end else if (flush) begin
      for (int k = 0; k < NUM_CH; k++) begin
        state_q[k]  <= S_IDLE;
        cnt_q[k]    <= '0;
        rd_ptr_q[k] <= '0;
        wr_ptr_q[k] <= '0;
        count_q[k]  <= '0;
      end
      fresh_q       <= '0;
      pulse_valid_q <= '0;
      err_q         <= 1'b0;
    end else begin
      fresh_q       <= push;
      pulse_valid_q <= fire;
      err_q         <= in_valid && in_ready && bad_ch;
      for (int k = 0; k < NUM_CH; k++) begin
        if (push[k]) wr_ptr_q[k] <= wr_ptr_q[k] + 1'b1;
        if (load[k]) rd_ptr_q[k] <= rd_ptr_q[k] + 1'b1;
        if (push[k] && !load[k])      count_q[k] <= count_q[k] + 1'b1;
        else if (!push[k] && load[k]) count_q[k] <= count_q[k] - 1'b1;
        if (fire[k]) pulse_addr_q[k] <= addr_q[k];
        if (!pause) begin
          if (load[k]) begin
            state_q[k] <= S_WAIT;
            cnt_q[k]   <= mem_q[k][rd_ptr_q[k]][ADDR_W +: DELAY_W];
          end else if ((state_q[k] == S_WAIT) && (cnt_q[k] != '0)) begin
            cnt_q[k] <= cnt_q[k] - 1'b1;
          end else if (fire[k]) begin
            state_q[k] <= S_IDLE;
          end
        end
      end
    end
  end

  // Descriptor storage and loaded address (data only, no reset needed)
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (push[k]) mem_q[k][wr_ptr_q[k]] <= {in_delay, in_addr};
      if (load[k] && !flush) addr_q[k] <= mem_q[k][rd_ptr_q[k]][ADDR_W-1:0];
    end
  end

  // Flatten per-channel fired addresses onto the output bus
  always_comb begin
    pulse_addr = '0;
    for (int k = 0; k < NUM_CH; k++)
      pulse_addr[k*ADDR_W +: ADDR_W] = pulse_addr_q[k];
  end

  assign pulse_valid = pulse_valid_q;
  assign err_bad_ch  = err_q;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Bench for pulse_sequencer: a queue-based reference model is compared on every cycle,
// with directed scenarios pinned by literal timing, and a randomized phase after them.
// A second 3-channel instance exercises the out-of-range channel path.
module tb_pulse_sequencer;
  localparam int NCH = 4, DEPTH = 8, DW = 16, AW = 12;

  logic clk = 1'b0;
  logic reset;
  logic in_valid, pause, flush;
  logic [1:0] in_ch;
  logic [DW-1:0] in_delay;
  logic [AW-1:0] in_addr;
  logic in_ready, idle, err_bad_ch;
  logic [NCH-1:0] pulse_valid, ch_full;
  logic [NCH*AW-1:0] pulse_addr;

  logic in_valid2;
  logic [1:0] in_ch2;
  logic in_ready2, idle2, err2;
  logic [2:0] pulse_valid2, ch_full2;
  logic [3*AW-1:0] pulse_addr2;

  int checks = 0, errors = 0, ecount = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  pulse_sequencer #(.NUM_CH(NCH), .DEPTH(DEPTH), .DELAY_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
    .in_delay(in_delay), .in_addr(in_addr), .pause(pause), .flush(flush),
    .pulse_valid(pulse_valid), .pulse_addr(pulse_addr), .ch_full(ch_full),
    .idle(idle), .err_bad_ch(err_bad_ch));

  pulse_sequencer #(.NUM_CH(3), .DEPTH(4), .DELAY_W(DW), .ADDR_W(AW)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2), .in_ch(in_ch2),
    .in_delay(16'd0), .in_addr(12'h055), .pause(1'b0), .flush(1'b0),
    .pulse_valid(pulse_valid2), .pulse_addr(pulse_addr2), .ch_full(ch_full2),
    .idle(idle2), .err_bad_ch(err2));

  // ---------------- reference model ----------------
  typedef struct { int d; int a; int t; } ent_t;
  ent_t mq [NCH][$];
  bit   m_arm [NCH];
  int   m_left [NCH];
  int   m_cur [NCH];
  int   now;
  logic [NCH-1:0]    exp_pv;
  logic [NCH*AW-1:0] exp_pa;
  logic              exp_err;

  // A loaded descriptor fires on the (D+1)-th unpaused edge after its load edge;
  // an entry pushed on edge N can be loaded no earlier than edge N+2.
  always @(posedge clk or posedge reset) begin : model
    bit acc;
    if (reset) begin
      for (int k = 0; k < NCH; k++) begin
        mq[k].delete(); m_arm[k] = 0; m_left[k] = 0; m_cur[k] = 0;
      end
      exp_pv = '0; exp_pa = '0; exp_err = 1'b0; now = 0;
    end else begin
      now++;
      exp_pv = '0; exp_err = 1'b0;
      acc = in_valid && !flush && (mq[in_ch].size() < DEPTH);
      if (flush) begin
        for (int k = 0; k < NCH; k++) begin mq[k].delete(); m_arm[k] = 0; end
      end else begin
        for (int k = 0; k < NCH; k++) begin
          if (!pause) begin
            if (m_arm[k]) begin
              if (m_left[k] == 0) begin
                exp_pv[k] = 1'b1;
                exp_pa[k*AW +: AW] = AW'(m_cur[k]);
                m_arm[k] = 0;
              end else m_left[k]--;
            end
            if (!m_arm[k] && mq[k].size() > 0 && mq[k][0].t <= now - 2) begin
              m_arm[k] = 1; m_left[k] = mq[k][0].d; m_cur[k] = mq[k][0].a;
              void'(mq[k].pop_front());
            end
          end
        end
        if (acc) mq[in_ch].push_back('{int'(in_delay), int'(in_addr), now});
      end
    end
  end

  function automatic logic exp_ready();
    if (reset !== 1'b0) return 1'b0;
    return mq[in_ch].size() < DEPTH;
  endfunction

  function automatic logic [NCH-1:0] exp_full();
    logic [NCH-1:0] f = '0;
    for (int k = 0; k < NCH; k++) f[k] = (mq[k].size() == DEPTH);
    return f;
  endfunction

  function automatic logic exp_idle();
    for (int k = 0; k < NCH; k++) if (mq[k].size() != 0 || m_arm[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic cmp(string nm, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Every-cycle comparison of the DUT against the model, away from the clock edge
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("in_ready", 64'(in_ready), 64'(exp_ready()));
      cmp("pulse_valid", 64'(pulse_valid), 64'(exp_pv));
      cmp("pulse_addr", 64'(pulse_addr), 64'(exp_pa));
      cmp("ch_full", 64'(ch_full), 64'(exp_full()));
      cmp("idle", 64'(idle), 64'(exp_idle()));
      cmp("err_bad_ch", 64'(err_bad_ch), 64'(exp_err));
    end
  end

  // ---------------- stimulus helpers ----------------
  int fq[$];
  logic [NCH-1:0] fv[$];

  task automatic step();
    @(posedge clk); #1; ecount++;
  endtask

  task automatic push(int ch, int d, int a);
    in_valid = 1'b1; in_ch = 2'(ch); in_delay = DW'(d); in_addr = AW'(a);
  endtask

  task automatic watch(int n, logic [NCH-1:0] mask, int base);
    fq.delete(); fv.delete();
    repeat (n) begin
      step();
      if ((pulse_valid & mask) != 0) begin fq.push_back(ecount - base); fv.push_back(pulse_valid); end
    end
  endtask

  int base, n2;

  initial begin
    in_valid = 0; in_ch = 0; in_delay = 0; in_addr = 0; pause = 0; flush = 0;
    in_valid2 = 0; in_ch2 = 0;
    reset = 1'b1;
    #1 chk_en = 1;

    // T1 reset
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cmp("t1_ready_in_reset", 64'(in_ready), 64'd0);
    cmp("t1_idle", 64'(idle), 64'd1);
    cmp("t1_pv", 64'(pulse_valid), 64'd0);
    cmp("t1_full", 64'(ch_full), 64'd0);
    cmp("t1_addr", 64'(pulse_addr), 64'd0);
    reset = 1'b0; #1;
    cmp("t1_ready_after", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    repeat (2) step();

    // T2 single pulse
    push(2, 5, 12'h0A3); step(); base = ecount; in_valid = 0;
    watch(14, 4'b1111, base);
    cmp("t2_nfires", 64'(fq.size()), 64'd1);
    if (fq.size() == 1) begin
      cmp("t2_edge", 64'(fq[0]), 64'd8);
      cmp("t2_pv", 64'(fv[0]), 64'b0100);
    end
    cmp("t2_addr", 64'(pulse_addr[2*AW +: AW]), 64'h0A3);

    // T3 spacing, then filling ch1 under pause
    push(0, 0, 1); step(); base = ecount;
    push(0, 3, 2); step();
    push(0, 1, 3); step(); in_valid = 0;
    watch(15, 4'b0001, base);
    cmp("t3_nfires", 64'(fq.size()), 64'd3);
    if (fq.size() == 3) begin
      cmp("t3_first", 64'(fq[0]), 64'd3);
      cmp("t3_gap1", 64'(fq[1] - fq[0]), 64'd4);
      cmp("t3_gap2", 64'(fq[2] - fq[0]), 64'd6);
    end
    cmp("t3_addr0", 64'(pulse_addr[AW-1:0]), 64'h3);
    pause = 1;
    for (int i = 0; i < 8; i++) begin push(1, 0, 12'h100 + i); step(); end
    #1;
    cmp("t3_full1", 64'(ch_full[1]), 64'd1);
    cmp("t3_refuse", 64'(in_ready), 64'd0);
    push(1, 0, 12'h1FF); step();
    in_valid = 0; pause = 0;
    watch(30, 4'b0010, ecount);
    cmp("t3_ch1_fires", 64'(fq.size()), 64'd8);
    cmp("t3_ch1_last", 64'(pulse_addr[AW +: AW]), 64'h107);

    // T4 pause stretches the countdown by exactly the paused cycles
    push(3, 10, 12'h333); step(); base = ecount; in_valid = 0;
    fq.delete();
    for (int i = 1; i <= 25; i++) begin
      pause = (i >= 5 && i <= 8);
      step();
      if (pulse_valid[3]) fq.push_back(ecount - base);
    end
    pause = 0;
    cmp("t4_nfires", 64'(fq.size()), 64'd1);
    if (fq.size() == 1) cmp("t4_edge", 64'(fq[0]), 64'd17);

    // T5 simultaneous fire, then flush with entries queued
    pause = 1;
    push(0, 2, 12'h011); step(); base = ecount;
    push(1, 2, 12'h022); step();
    in_valid = 0; step();
    pause = 0;
    watch(8, 4'b1111, base);
    cmp("t5_nfires", 64'(fq.size()), 64'd1);
    if (fq.size() == 1) begin
      cmp("t5_edge", 64'(fq[0]), 64'd6);
      cmp("t5_pv", 64'(fv[0]), 64'b0011);
    end
    push(0, 5, 12'h0F1); step();
    push(0, 5, 12'h0F2); step();
    push(0, 5, 12'h0F3); step(); in_valid = 0;
    step();
    flush = 1; step(); flush = 0;
    cmp("t5_idle_after_flush", 64'(idle), 64'd1);
    watch(20, 4'b1111, ecount);
    cmp("t5_no_fire", 64'(fq.size()), 64'd0);
    cmp("t5_addr_kept", 64'(pulse_addr[AW-1:0]), 64'h011);

    // T6 reset mid-WAIT, then bad channel on the 3-channel instance
    push(1, 6, 12'h0AA); step(); in_valid = 0;
    repeat (5) step();
    reset = 1; #1;
    cmp("t6_pv_in_reset", 64'(pulse_valid), 64'd0);
    cmp("t6_idle_in_reset", 64'(idle), 64'd1);
    repeat (2) step();
    reset = 0;
    watch(15, 4'b1111, ecount);
    cmp("t6_no_fire", 64'(fq.size()), 64'd0);
    in_valid2 = 1; in_ch2 = 2'd3; #1;
    cmp("t6_bad_ready", 64'(in_ready2), 64'd1);
    step(); in_valid2 = 0;
    cmp("t6_err", 64'(err2), 64'd1);
    step();
    cmp("t6_err_clear", 64'(err2), 64'd0);
    n2 = 0;
    repeat (10) begin step(); if (pulse_valid2 != 0) n2++; end
    cmp("t6_bad_no_fire", 64'(n2), 64'd0);
    cmp("t6_bad_idle", 64'(idle2), 64'd1);

    // Randomized phase
    for (int i = 0; i < 4000; i++) begin
      if (reset) reset = 0;
      else if ($urandom_range(0, 999) < 3) reset = 1;
      if ($urandom_range(0, 99) < 8) pause = ~pause;
      flush    = ($urandom_range(0, 99) < 2);
      in_valid = ($urandom_range(0, 99) < 60);
      in_ch    = 2'($urandom_range(0, 3));
      in_delay = DW'($urandom_range(0, 6));
      in_addr  = AW'($urandom);
      step();
    end
    in_valid = 0; pause = 0; flush = 0; reset = 0;
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
